// File: rtl/hex_pkg.sv
// Shared definitions for the HEX sweep renderer: digit geometry, active-low
// segment codes, the renderer FSM state type and a column range helper.
package hex_pkg;

   localparam int unsigned NUM_DIGITS = 6;
   localparam int unsigned SEG_W      = 7;
   localparam int unsigned COL_W      = 3;

   typedef logic [SEG_W-1:0] seg_t;

   // Active-low segment patterns, bit 0 = a ... bit 6 = g.
   localparam seg_t BLANK   = 7'h7F;
   localparam seg_t ALL     = 7'h00;
   localparam seg_t TRAIL   = 7'h3F;  // g only
   localparam seg_t HEAD_UP = 7'h79;  // b, c
   localparam seg_t HEAD_DN = 7'h4F;  // e, f
   localparam seg_t ERR     = 7'h06;  // "E"

   typedef enum logic [1:0] {
      IDLE,
      BOUNCE,
      ERROR
   } render_state_t;

   function automatic logic col_legal(input logic [COL_W-1:0] col);
      return col < COL_W'(NUM_DIGITS);
   endfunction

endpackage

// File: rtl/sweep_trail_history.sv
// Trail history: a TRAIL_LEN-deep shift register of previously visited columns.
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   push            : shift in push_col as the newest entry, drop the oldest
//   push_col        : column to record
//   clear           : invalidate every entry (wins over push)
//   hit             : per-digit flag, set when any valid entry names that digit
module sweep_trail_history
   import hex_pkg::*;
#(
   parameter int unsigned TRAIL_LEN = 2
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  push,
   input  logic [COL_W-1:0]      push_col,
   input  logic                  clear,
   output logic [NUM_DIGITS-1:0] hit
);

   if (TRAIL_LEN > 0) begin : g_hist
      logic [COL_W-1:0]     hist_col_q [TRAIL_LEN];
      logic [TRAIL_LEN-1:0] hist_vld_q;

      always_ff @(posedge clk_i or negedge reset_ni) begin
         if (!reset_ni) begin
            for (int i = 0; i < int'(TRAIL_LEN); i++) begin
               hist_col_q[i] <= '0;
            end
            hist_vld_q <= '0;
         end else if (clear) begin
            hist_vld_q <= '0;
         end else if (push) begin
            hist_col_q[0] <= push_col;
            hist_vld_q[0] <= 1'b1;
            for (int i = 1; i < int'(TRAIL_LEN); i++) begin
               hist_col_q[i] <= hist_col_q[i-1];
               hist_vld_q[i] <= hist_vld_q[i-1];
            end
         end
      end

      always_comb begin
         hit = '0;
         for (int i = 0; i < int'(TRAIL_LEN); i++) begin
            for (int d = 0; d < int'(NUM_DIGITS); d++) begin
               if (hist_vld_q[i] && (hist_col_q[i] == COL_W'(d))) begin
                  hit[d] = 1'b1;
               end
            end
         end
      end
   end else begin : g_no_hist
      // No storage: nothing is ever drawn as trail.
      logic unused_inputs;
      assign unused_inputs = ^{clk_i, reset_ni, push, push_col, clear};
      assign hit = '0;
   end

endmodule

// File: rtl/hex_sweep_renderer.sv
// Renders the sweep controller's column/direction onto six active-low 7-segment
// digits: direction-dependent head, fading trail, "8" while bouncing, "E" on a
// bad column. Two register stages: inputs -> (col_q, dir_q, FSM, history) -> hex_o.
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   col_i           : active column, legal 0..5
//   direction_i     : 0 = ascending, 1 = descending
//   hex_o           : digit k on hex_o[7k+6:7k], active-low
module hex_sweep_renderer
   import hex_pkg::*;
#(
   parameter int unsigned TRAIL_LEN = 2
) (
   input  logic                          clk_i,
   input  logic                          reset_ni,
   input  logic [COL_W-1:0]              col_i,
   input  logic                          direction_i,
   output logic [NUM_DIGITS*SEG_W-1:0]   hex_o
);

   logic [COL_W-1:0]            col_q;
   logic                        dir_q;
   render_state_t               state_q, state_d;
   logic                        push, clear;
   logic [NUM_DIGITS-1:0]       hit;
   logic [NUM_DIGITS*SEG_W-1:0] hex_d;

   // Stage 1: input register.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         col_q <= '0;
         dir_q <= 1'b0;
      end else begin
         col_q <= col_i;
         dir_q <= direction_i;
      end
   end

   // Change detection compares the incoming value with col_q/dir_q, so the FSM
   // state and history update on the same edge that col_q/dir_q take the new
   // value. All three are then consistent when the composer reads them.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!col_legal(col_i)) begin
         state_d = ERROR;
      end else if (state_q == ERROR) begin
         state_d = IDLE;
      end else if (col_i != col_q) begin
         // A column change wins over a simultaneous direction change.
         state_d = IDLE;
      end else if (direction_i != dir_q) begin
         state_d = BOUNCE;
      end
   end

   // History control. Leaving ERROR does not push: the column being left is
   // out of range and the trail restarts empty.
   always_comb begin
      push  = 1'b0;
      clear = 1'b0;
      if (!col_legal(col_i)) begin
         clear = 1'b1;
      end else if ((state_q != ERROR) && (col_i != col_q)) begin
         push = 1'b1;
      end
   end

   sweep_trail_history #(
      .TRAIL_LEN (TRAIL_LEN)
   ) u_history (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .push     (push),
      .push_col (col_q),
      .clear    (clear),
      .hit      (hit)
   );

   // Digit composer: error > head > trail > blank.
   always_comb begin
      hex_d = '1;
      for (int d = 0; d < int'(NUM_DIGITS); d++) begin
         if (state_q == ERROR) begin
            hex_d[d*SEG_W +: SEG_W] = ERR;
         end else if (col_q == COL_W'(d)) begin
            if (state_q == BOUNCE) begin
               hex_d[d*SEG_W +: SEG_W] = ALL;
            end else begin
               hex_d[d*SEG_W +: SEG_W] = dir_q ? HEAD_DN : HEAD_UP;
            end
         end else if (hit[d]) begin
            hex_d[d*SEG_W +: SEG_W] = TRAIL;
         end else begin
            hex_d[d*SEG_W +: SEG_W] = BLANK;
         end
      end
   end

   // Stage 2: output register.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         hex_o <= '1;
      end else begin
         hex_o <= hex_d;
      end
   end

endmodule

// File: tb/tb_hex_sweep_renderer.sv
module tb_hex_sweep_renderer;

   localparam logic [6:0] B  = 7'h7F;
   localparam logic [6:0] AL = 7'h00;
   localparam logic [6:0] TR = 7'h3F;
   localparam logic [6:0] UP = 7'h79;
   localparam logic [6:0] DN = 7'h4F;
   localparam logic [6:0] ER = 7'h06;

   logic        clk;
   logic        reset_n;
   logic [2:0]  col;
   logic        dir;
   logic [41:0] hex2;   // TRAIL_LEN = 2
   logic [41:0] hex0;   // TRAIL_LEN = 0

   int checks = 0;
   int passed = 0;

   hex_sweep_renderer #(.TRAIL_LEN(2)) dut (
      .clk_i       (clk),
      .reset_ni    (reset_n),
      .col_i       (col),
      .direction_i (dir),
      .hex_o       (hex2)
   );

   hex_sweep_renderer #(.TRAIL_LEN(0)) dut0 (
      .clk_i       (clk),
      .reset_ni    (reset_n),
      .col_i       (col),
      .direction_i (dir),
      .hex_o       (hex0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [41:0] pat(input logic [6:0] d5, d4, d3, d2, d1, d0);
      return {d5, d4, d3, d2, d1, d0};
   endfunction

   function automatic logic [41:0] head_only(input int c, input logic d);
      logic [41:0] r;
      r = '1;
      r[c*7 +: 7] = d ? DN : UP;
      return r;
   endfunction

   function automatic int nonblank(input logic [41:0] h);
      int n;
      n = 0;
      for (int k = 0; k < 6; k++) if (h[k*7 +: 7] != B) n++;
      return n;
   endfunction

   task automatic chk(input string tag, input logic [41:0] got, input logic [41:0] exp);
      checks++;
      assert (got === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   initial begin
      reset_n = 1'b1;
      col     = 3'd0;
      dir     = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      chk("reset_blank_t2", hex2, '1);
      chk("reset_blank_t0", hex0, '1);
      tick(2);
      reset_n = 1'b1;
      tick(2);
      chk("first_head_t2", hex2, pat(B, B, B, B, B, UP));
      chk("first_head_t0", hex0, pat(B, B, B, B, B, UP));

      // Back-to-back column changes.
      col = 3'd1; tick(1);
      col = 3'd2; tick(1);
      col = 3'd3; tick(2);
      chk("trail_0123_t2", hex2, pat(B, B, UP, TR, TR, B));
      chk("trail_0123_t0", hex0, pat(B, B, UP, B, B, B));

      // Two-clock latency: unchanged after one clock.
      col = 3'd4; tick(1);
      chk("latency_1clk", hex2, pat(B, B, UP, TR, TR, B));
      tick(1);
      chk("latency_2clk", hex2, pat(B, UP, TR, TR, B, B));
      col = 3'd5; tick(2);
      chk("col5", hex2, pat(UP, TR, TR, B, B, B));

      // Bounce at the top end, then leave it.
      dir = 1'b1; tick(2);
      chk("bounce5", hex2, pat(AL, TR, TR, B, B, B));
      col = 3'd4; tick(2);
      chk("after_bounce_t2", hex2, pat(TR, DN, B, B, B, B));
      chk("after_bounce_t0", hex0, pat(B, DN, B, B, B, B));
      col = 3'd3; tick(2);
      chk("down3", hex2, pat(TR, TR, DN, B, B, B));

      // Simultaneous col+dir change is a push, not a bounce.
      col = 3'd2; dir = 1'b0; tick(2);
      chk("simul_change", hex2, pat(B, TR, TR, UP, B, B));
      // Non-adjacent jump.
      col = 3'd0; tick(2);
      chk("jump_2_to_0", hex2, pat(B, B, TR, TR, B, UP));

      // Out-of-range column for three cycles.
      col = 3'd6; tick(2);
      chk("error_t2", hex2, pat(ER, ER, ER, ER, ER, ER));
      chk("error_t0", hex0, pat(ER, ER, ER, ER, ER, ER));
      tick(1);
      col = 3'd2; dir = 1'b0; tick(2);
      chk("recover_t2", hex2, pat(B, B, B, UP, B, B));
      chk("recover_t0", hex0, pat(B, B, B, UP, B, B));
      col = 3'd3; tick(2);
      chk("resume_push", hex2, pat(B, B, UP, TR, B, B));

      // Asynchronous reset mid-bounce.
      dir = 1'b1; tick(2);
      chk("bounce3", hex2, pat(B, B, AL, TR, B, B));
      #3 reset_n = 1'b0;
      #1;
      chk("async_reset_t2", hex2, '1);
      chk("async_reset_t0", hex0, '1);
      col = 3'd0; dir = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(2);
      chk("post_reset", hex2, pat(B, B, B, B, B, UP));

      // Full sweep; the TRAIL_LEN = 0 instance only ever shows the head.
      for (int c = 1; c <= 5; c++) begin
         col = 3'(c); tick(2);
         chk("zero_up", hex0, head_only(c, 1'b0));
         chk_cnt("zero_up_cnt", nonblank(hex0), 1);
      end
      dir = 1'b1; tick(2);
      chk("zero_bounce", hex0, pat(AL, B, B, B, B, B));
      chk_cnt("zero_bounce_cnt", nonblank(hex0), 1);
      for (int c = 4; c >= 0; c--) begin
         col = 3'(c); tick(2);
         chk("zero_down", hex0, head_only(c, 1'b1));
         chk_cnt("zero_down_cnt", nonblank(hex0), 1);
      end
      chk("sweep_end_t2", hex2, pat(B, B, B, TR, TR, DN));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/hex_sweep_renderer.md
# hex_sweep_renderer

Downstream consumer of the column/direction sweep controller. It samples the controller's column index and direction each clock and drives six active-low 7-segment digits on the DE10-Lite HEX0..HEX5. The picture it draws is:
- a direction-dependent head marker at the active column;
- a fading trail of previously visited columns;
- a full-"8" bounce marker while the sweep reverses at an end;
- an "E" error pattern on all digits if the column index goes out of range.

## Interface
- TRAIL_LEN, 2: number of previous distinct columns shown as trail; legal 0..5.
- clk_i  in  1  system clock (same domain as the controller).
- reset_ni  in  1  asynchronous, active-low reset.
- col_i  in  3  active column from the controller; legal 0..5.
- direction_i  in  1  sweep direction: 0 = ascending, 1 = descending.
- hex_o  out  42  segment outputs, active-low.
  - Digit k occupies hex_o[7k+6:7k].
  - Within a digit, bit 0 = segment a through bit 6 = segment g.

## Operation
- Stage 1 (input register): col_i and direction_i are registered into col_q and dir_q every cycle. There is no step strobe; behaviour is driven purely by input changes.
- Segment codes:
  - BLANK = 7'h7F
  - ALL = 7'h00
  - TRAIL (g only) = 7'h3F
  - HEAD_UP (b,c) = 7'h79
  - HEAD_DN (e,f) = 7'h4F
  - ERR ("E") = 7'h06
- Trail history:
  - Shift register of TRAIL_LEN entries, each holding a 3-bit column plus a valid bit.
  - When col_q changes to a legal value, the previous col_q is pushed into entry 0 and older entries shift up. The oldest entry is dropped.
  - An unchanged col_q does not push.
  - With TRAIL_LEN = 0 the history is absent and no trail is drawn.
- FSM states: IDLE, BOUNCE, ERROR.
  - IDLE to BOUNCE: dir_q changes while col_q is unchanged and legal.
  - BOUNCE to IDLE: col_q changes to a legal value. That cycle also pushes the history.
  - Any state to ERROR: col_q > 5. On entry, the whole history is invalidated.
  - ERROR to IDLE: col_q is legal. History stays empty; normal pushes resume on the next change.
- Digit composition (priority from highest):
  1. ERROR: every digit shows ERR.
  2. Head digit (index col_q):
     - BOUNCE: ALL.
     - Otherwise: HEAD_UP if dir_q = 0, HEAD_DN if dir_q = 1.
  3. A digit matching any valid trail entry shows TRAIL.
  4. All other digits show BLANK.
- The head always overrides the trail when they coincide.
- Stage 2 (output register): hex_o is registered. There are no combinational paths from inputs to outputs.

## Timing
- Latency: a change on col_i or direction_i appears on hex_o exactly 2 clocks later.
- Throughput: back-to-back column changes on consecutive cycles are each pushed. Every change is honoured, with no minimum dwell.
- Reset (asynchronous assert, synchronous-to-clock release):
  - hex_o = all 1s (every digit BLANK).
  - col_q = 0, dir_q = 0.
  - History all invalid; state IDLE.
- First legal rendering appears 2 clocks after reset release.
- Reset asserted mid-sweep or mid-BOUNCE blanks hex_o immediately, independent of the clock.
- Simultaneous change of col and dir in one cycle: treated as a column change (push). BOUNCE is not entered.
- Column transition 5 to 0 (or any jump): legal, pushes normally. No adjacency check.

## Structure
- Shared package hex_pkg holds:
  - NUM_DIGITS = 6, SEG_W = 7, COL_W = 3;
  - the six segment-code constants;
  - typedef seg_t (logic [6:0]);
  - the enum render_state_t {IDLE, BOUNCE, ERROR}.
- One sub-module, sweep_trail_history. It holds the TRAIL_LEN shift register with these ports:
  - push, push_col, clear;
  - a per-digit hit vector (6 bits).
- Top level: input register, FSM, digit composer, output register.

## Test plan
- Reset, then col_i = 0, dir = 0 held → after 2 clocks hex_o[6:0] = 0x79, digits 1..5 = 0x7F.
- TRAIL_LEN = 2, col 0→1→2→3 on consecutive cycles → final state: digit3 = 0x79, digits 2 and 1 = 0x3F, digit0 = 0x7F.
- Sweep to col 5, dir 0→1 with col held → digit5 = 0x00 two clocks later; then col 4 → digit4 = 0x4F, digit5 = 0x3F, FSM back in IDLE.
- col_i = 6 for 3 cycles, then col_i = 2, dir = 0:
  - during the error: all digits = 0x06;
  - after recovery: digit2 = 0x79, others 0x7F (history cleared).
- Mid-BOUNCE, assert reset_ni low between clock edges → hex_o = all 1s immediately. After release with col 0, dir 0: digit0 = 0x79 two clocks later, with no stale trail.
- TRAIL_LEN = 0 full up/down sweep → only the head digit is ever non-BLANK, and at most one digit is non-0x7F at any time.
